fifo_ptr_ctrl: RTL and testbench
================================

# fifo_ptr_ctrl

Pointer and flag controller for the SpaceWire receive/transmit FIFOs. Drives the `wr_ptr`/`rd_ptr` inputs of the `mem_data` storage array. Turns push/pop requests into committed pointer moves and keeps occupancy, full/empty flags and a read-valid strobe aligned to the array's one-cycle registered read. `mem_data` writes `MEM[wr_ptr]` unconditionally on every clock, so this block never lets `wr_ptr` land on an unread entry.

## Interface
Parameters:
- `AWIDTH`, default 6: pointer width. Array depth is 2^AWIDTH; usable capacity is 2^AWIDTH-1 entries.

Ports:
- `clock`  in  1  sole clock; all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high).
- `wr_en`  in  1  push request; data is presented on the `mem_data` `data_in` in the same cycle.
- `rd_en`  in  1  pop request.
- `wr_ptr`  out  AWIDTH  write address to `mem_data`; registered.
- `rd_ptr`  out  AWIDTH  read address to `mem_data`; registered.
- `count`  out  AWIDTH  occupancy, 0..2^AWIDTH-1; registered.
- `full`  out  1  registered; 1 when `count` == 2^AWIDTH-1.
- `empty`  out  1  registered; 1 when `count` == 0.
- `rd_valid`  out  1  1 in the cycle in which `mem_data` `data_out` holds a popped entry.
- `overflow`  out  1  sticky; present only with `FIFO_CTRL_ERR_FLAGS_EN`.
- `underflow`  out  1  sticky; present only with `FIFO_CTRL_ERR_FLAGS_EN`.

## Operation
- push_ok = `wr_en` & !`full`; pop_ok = `rd_en` & !`empty`. Both use the registered flags.
- push_ok: `wr_ptr` <= `wr_ptr`+1, modulo 2^AWIDTH. The slot just written is committed. The new `wr_ptr` slot is scratch and gets overwritten every clock.
- pop_ok: `rd_ptr` <= `rd_ptr`+1, modulo 2^AWIDTH.
- `count` update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both or neither: unchanged.
- Flags are recomputed from the next `count`, so they are valid in the cycle after the edge.
- Capacity is held at 2^AWIDTH-1 so that `wr_ptr` never equals `rd_ptr` while entries are pending, except when empty.
- Wrap-around: pointers roll from 2^AWIDTH-1 to 0 with no special handling. Full/empty come from `count`, not from pointer compare.
- Simultaneous push and pop:
  - Full: pop accepted, push rejected. Result is `count` -1 and `full`=0 next cycle.
  - Empty: push accepted, pop rejected. Result is `count`=1.
  - Otherwise: both accepted, `count` unchanged.
- Rejected requests change no state, apart from the error flags when enabled.
- Reset, including mid-operation: `wr_ptr`=0, `rd_ptr`=0, `count`=0, `empty`=1, `full`=0, `rd_valid`=0, `overflow`=0, `underflow`=0. Pending contents are discarded. The `mem_data` array is not cleared by this block.

## Timing
- Push at edge N: the entry is written into `mem_data` at edge N. `empty` deasserts and `count` increments after edge N.
- Pop accepted at edge N: `mem_data` samples `MEM[rd_ptr]` (the old pointer) at edge N. `data_out` holds the entry after edge N. `rd_valid` = 1 in that same cycle, i.e. `rd_valid` <= pop_ok.
- First-word latency: a push at edge N makes a pop possible at edge N+1, with data and `rd_valid` after edge N+1.
- Back-to-back pops sustain one entry per clock. `rd_valid` stays high continuously.
- No combinational path from `wr_en`/`rd_en` to any output.

## Configuration
- `FIFO_CTRL_ERR_FLAGS_EN` defined:
  - `overflow` is set when `wr_en` & `full`.
  - `underflow` is set when `rd_en` & `empty`.
  - Both are sticky until `reset`.
- `FIFO_CTRL_ERR_FLAGS_EN` undefined: the ports and logic are omitted, and rejected requests are silently dropped.

## Test plan
- Reset, then idle 3 clocks -> `empty`=1, `full`=0, `count`=0, both pointers 0, `rd_valid`=0.
- Push 0x1A5, then pop the next cycle -> `count` goes 1 then 0. `data_out`=0x1A5 with `rd_valid`=1 one clock after the pop. `empty`=1 afterwards.
- AWIDTH=6, push 63 entries -> `full`=1, `count`=63, `wr_ptr`=63. A 64th push is rejected with pointers unchanged, and `overflow`=1 when the macro is defined. Pop all 63 -> in-order data, `rd_ptr` wraps to 63 then 0 after the next cycle's accounting.
- At `full`, assert `wr_en` and `rd_en` together -> `count`=62, `full`=0, `rd_ptr` +1, `wr_ptr` unchanged. At `empty`, both together -> `count`=1, no `rd_valid`, `underflow`=1 when the macro is defined.
- Streaming: push and pop every cycle for 200 cycles starting from `count`=5 -> `count` stays at 5, pointers wrap 3 times, data order is preserved, `rd_valid` is continuous.
- Assert `reset` for one clock with `count`=40 -> all outputs return to reset values on the next cycle, and sticky flags clear.

Source files
------------

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and flag controller for the SpaceWire FIFOs driving the mem_data array.
// Optional sticky overflow/underflow flags are built only when FIFO_CTRL_ERR_FLAGS_EN is defined.
module fifo_ptr_ctrl #(
   parameter int AWIDTH = 6
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic              rd_en,
   output logic [AWIDTH-1:0] wr_ptr,
   output logic [AWIDTH-1:0] rd_ptr,
   output logic [AWIDTH-1:0] count,
   output logic              full,
   output logic              empty,
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   output logic              rd_valid,
   output logic              overflow,
   output logic              underflow
`else
   output logic              rd_valid
`endif
);

   // One slot is held back so wr_ptr never lands on an unread entry.
   localparam logic [AWIDTH-1:0] CNT_MAX = '1;
   localparam logic [AWIDTH-1:0] ONE     = AWIDTH'(1);

   logic              push_ok;
   logic              pop_ok;
   logic [AWIDTH-1:0] count_nxt;
   logic [AWIDTH-1:0] wr_ptr_nxt;
   logic [AWIDTH-1:0] rd_ptr_nxt;

   always_comb begin
      push_ok    = wr_en & ~full;
      pop_ok     = rd_en & ~empty;
      count_nxt  = count;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      if (push_ok) begin
         wr_ptr_nxt = wr_ptr + ONE;
      end
      if (pop_ok) begin
         rd_ptr_nxt = rd_ptr + ONE;
      end
      case ({push_ok, pop_ok})
         2'b10:   count_nxt = count + ONE;
         2'b01:   count_nxt = count - ONE;
         default: count_nxt = count;
      endcase
   end

   // Flags follow the next count so they are valid right after the edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         rd_valid <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         count    <= count_nxt;
         full     <= (count_nxt == CNT_MAX);
         empty    <= (count_nxt == '0);
         rd_valid <= pop_ok;
      end
   end

`ifdef FIFO_CTRL_ERR_FLAGS_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= overflow | (wr_en & full);
         underflow <= underflow | (rd_en & empty);
      end
   end
`endif

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Directed bench for fifo_ptr_ctrl with a behavioural mem_data array and an occupancy scoreboard.
// Build with FIFO_CTRL_ERR_FLAGS_EN defined to also cover the sticky error flags.
module tb_fifo_ptr_ctrl;

   localparam int AW  = 6;
   localparam int CAP = (1 << AW) - 1;

   logic          clock;
   logic          reset;
   logic          wr_en;
   logic          rd_en;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] count;
   logic          full;
   logic          empty;
   logic          rd_valid;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   logic          overflow;
   logic          underflow;
`endif

   logic [8:0] data_in;
   logic [8:0] data_out;
   logic [8:0] mem [1 << AW];

   fifo_ptr_ctrl #(.AWIDTH(AW)) dut (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .full     (full),
      .empty    (empty),
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      .rd_valid (rd_valid),
      .overflow (overflow),
      .underflow(underflow)
`else
      .rd_valid (rd_valid)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Storage array: unconditional write at wr_ptr, registered read at rd_ptr.
   always @(posedge clock) begin
      mem[wr_ptr] <= data_in;
      data_out    <= mem[rd_ptr];
   end

   int n_checks;
   int n_fail;

   logic [8:0]    q[$];
   logic [AW-1:0] m_wp;
   logic [AW-1:0] m_rp;
   int            m_count;
   logic          m_rv;
   logic [8:0]    m_data;
   logic          m_ovf;
   logic          m_udf;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("count", int'(count), m_count);
      chk("full", int'(full), int'(m_count == CAP));
      chk("empty", int'(empty), int'(m_count == 0));
      chk("rd_valid", int'(rd_valid), int'(m_rv));
      chk("wr_ptr", int'(wr_ptr), int'(m_wp));
      chk("rd_ptr", int'(rd_ptr), int'(m_rp));
      if (m_rv) chk("data_out", int'(data_out), int'(m_data));
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("underflow", int'(underflow), int'(m_udf));
`endif
   endtask

   task automatic cycle(input logic w, input logic r, input logic [8:0] d);
      logic push;
      logic pop;
      push    = w && (m_count != CAP);
      pop     = r && (m_count != 0);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      @(posedge clock);
      #1;
      if (w && m_count == CAP) m_ovf = 1'b1;
      if (r && m_count == 0)   m_udf = 1'b1;
      if (push) begin
         q.push_back(d);
         m_wp = m_wp + 1'b1;
      end
      if (pop) begin
         m_data = q.pop_front();
         m_rp   = m_rp + 1'b1;
      end
      m_count = q.size();
      m_rv    = pop;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      q.delete();
      m_wp = '0; m_rp = '0; m_count = 0; m_rv = 1'b0;
      m_ovf = 1'b0; m_udf = 1'b0;
      chk("rst_count", int'(count), 0);
      chk("rst_full", int'(full), 0);
      chk("rst_empty", int'(empty), 1);
      chk("rst_rd_valid", int'(rd_valid), 0);
      chk("rst_wr_ptr", int'(wr_ptr), 0);
      chk("rst_rd_ptr", int'(rd_ptr), 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_underflow", int'(underflow), 0);
`endif
   endtask

   typedef struct {
      logic          w;
      logic          r;
      logic [8:0]    din;
      logic [AW-1:0] e_count;
      logic [AW-1:0] e_wp;
      logic [AW-1:0] e_rp;
      logic          e_full;
      logic          e_empty;
      logic          e_rv;
      logic          chk_data;
      logic [8:0]    e_data;
   } vec_t;

   vec_t vecs[10];

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      data_in  = '0;

      //         w     r     din     cnt wp  rp  full  empty rv    chk   data
      vecs[0] = '{1'b0, 1'b0, 9'h000, 0,  0,  0,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[1] = '{1'b0, 1'b0, 9'h000, 0,  0,  0,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[2] = '{1'b0, 1'b0, 9'h000, 0,  0,  0,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[3] = '{1'b1, 1'b0, 9'h1A5, 1,  1,  0,  1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
      vecs[4] = '{1'b0, 1'b1, 9'h000, 0,  1,  1,  1'b0, 1'b1, 1'b1, 1'b1, 9'h1A5};
      vecs[5] = '{1'b0, 1'b0, 9'h000, 0,  1,  1,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000};
      vecs[6] = '{1'b1, 1'b1, 9'h0C3, 1,  2,  1,  1'b0, 1'b0, 1'b0, 1'b0, 9'h000};
      vecs[7] = '{1'b1, 1'b1, 9'h13C, 1,  3,  2,  1'b0, 1'b0, 1'b1, 1'b1, 9'h0C3};
      vecs[8] = '{1'b0, 1'b1, 9'h000, 0,  3,  3,  1'b0, 1'b1, 1'b1, 1'b1, 9'h13C};
      vecs[9] = '{1'b0, 1'b1, 9'h000, 0,  3,  3,  1'b0, 1'b1, 1'b0, 1'b0, 9'h000};

      @(posedge clock);
      #1;
      do_reset();

      for (int i = 0; i < 10; i++) begin
         cycle(vecs[i].w, vecs[i].r, vecs[i].din);
         chk($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_count));
         chk($sformatf("v%0d_wr_ptr", i), int'(wr_ptr), int'(vecs[i].e_wp));
         chk($sformatf("v%0d_rd_ptr", i), int'(rd_ptr), int'(vecs[i].e_rp));
         chk($sformatf("v%0d_full", i), int'(full), int'(vecs[i].e_full));
         chk($sformatf("v%0d_empty", i), int'(empty), int'(vecs[i].e_empty));
         chk($sformatf("v%0d_rd_valid", i), int'(rd_valid), int'(vecs[i].e_rv));
         if (vecs[i].chk_data)
            chk($sformatf("v%0d_data", i), int'(data_out), int'(vecs[i].e_data));
      end

      // Fill to capacity, reject one push, then drain through the full/both case.
      do_reset();
      for (int i = 0; i < CAP; i++) cycle(1'b1, 1'b0, 9'(9'h100 + i));
      chk("fill_full", int'(full), 1);
      chk("fill_count", int'(count), 63);
      chk("fill_wr_ptr", int'(wr_ptr), 63);
      cycle(1'b1, 1'b0, 9'h0AA);
      chk("rej_wr_ptr", int'(wr_ptr), 63);
      chk("rej_rd_ptr", int'(rd_ptr), 0);
      chk("rej_count", int'(count), 63);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("rej_overflow", int'(overflow), 1);
`endif
      cycle(1'b1, 1'b1, 9'h055);
      chk("fullboth_count", int'(count), 62);
      chk("fullboth_full", int'(full), 0);
      chk("fullboth_rd_ptr", int'(rd_ptr), 1);
      chk("fullboth_wr_ptr", int'(wr_ptr), 63);
      chk("fullboth_data", int'(data_out), 9'h100);
      for (int i = 1; i < CAP; i++) begin
         cycle(1'b0, 1'b1, 9'h000);
         chk("drain_data", int'(data_out), 9'h100 + i);
      end
      chk("drain_rd_ptr", int'(rd_ptr), 63);
      chk("drain_empty", int'(empty), 1);
      cycle(1'b1, 1'b1, 9'h077);
      chk("emptyboth_count", int'(count), 1);
      chk("emptyboth_rd_valid", int'(rd_valid), 0);
      chk("emptyboth_wr_ptr", int'(wr_ptr), 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("emptyboth_underflow", int'(underflow), 1);
`endif
      cycle(1'b0, 1'b1, 9'h000);
      chk("wrap_rd_ptr", int'(rd_ptr), 0);
      chk("wrap_data", int'(data_out), 9'h077);

      // Streaming at count 5: sticky flags must clear on the reset first.
      do_reset();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 9'(9'h020 + i));
      for (int i = 0; i < 200; i++) begin
         cycle(1'b1, 1'b1, 9'((i * 7 + 3) & 9'h1FF));
         chk("stream_rd_valid", int'(rd_valid), 1);
         chk("stream_count", int'(count), 5);
      end
      chk("stream_wr_ptr", int'(wr_ptr), 13);
      chk("stream_rd_ptr", int'(rd_ptr), 8);

      // Mid-operation reset at count 40.
      for (int i = 0; i < 35; i++) cycle(1'b1, 1'b0, 9'(9'h180 + i));
      chk("pre_rst_count", int'(count), 40);
      do_reset();
      cycle(1'b0, 1'b0, 9'h000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
